// File: rtl/signed_op_pkg.sv
// Shared encodings for the signed/unsigned op arbiter: op codes and FSM states.
package signed_op_pkg;

    localparam logic [1:0] OP_SHR = 2'd0;
    localparam logic [1:0] OP_CMP = 2'd1;
    localparam logic [1:0] OP_NEG = 2'd2;
    localparam logic [1:0] OP_ABS = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/signed_op_arbiter_if.sv
// Request/response bundle between two requesters (master) and the shared op unit (slave).
interface signed_op_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [3:0]         req_op;
    logic [1:0]         req_sgn;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_data;
    logic               rsp_flag;

    modport master (
        output req_valid, req_op, req_sgn, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
    );

    modport slave (
        input  req_valid, req_op, req_sgn, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flag
    );
endinterface

// File: rtl/signed_op_rr_arb.sv
// Two-way round-robin grant: on contention the requester not granted last time wins.
module signed_op_rr_arb (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req_valid,
    input  logic       advance,
    output logic       grant_valid,
    output logic       grant_id
);

    logic last_grant;

    assign grant_valid = |req_valid;
    assign grant_id    = (&req_valid) ? ~last_grant : req_valid[1];

    // Resets to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= 1'b1;
        end else if (advance) begin
            last_grant <= grant_id;
        end
    end

endmodule

// File: rtl/signed_op_arbiter.sv
// Shares one iterative shift/compare/negate/abs unit between two requesters,
// round-robin arbitrated, with a single id-tagged response channel.
module signed_op_arbiter
    import signed_op_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    signed_op_arbiter_if.slave  bus,
    output logic                busy
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    state_t           state_nxt;
    logic             grant_valid;
    logic             grant_id;
    logic             advance;

    logic [1:0]       op_q;
    logic             sgn_q;
    logic             id_q;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b_q;
    logic [SHW-1:0]   cnt;

    logic [1:0]       sel_op;
    logic             sel_sgn;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] res_data;
    logic             res_flag;

    signed_op_rr_arb u_arb (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (bus.req_valid),
        .advance    (advance),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    assign sel_op  = grant_id ? bus.req_op[3:2]            : bus.req_op[1:0];
    assign sel_sgn = grant_id ? bus.req_sgn[1]             : bus.req_sgn[0];
    assign sel_a   = grant_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
    assign sel_b   = grant_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults at the top of every always_comb keep each path assigned,
    // so no latches are inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (grant_valid)   state_nxt = ST_EXEC;
            ST_EXEC: if (cnt == '0)     state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Ready is gated by reset_n so it reads 0 while reset is held.
    always_comb begin
        bus.req_ready = 2'b00;
        advance       = 1'b0;
        busy          = (state != ST_IDLE);
        bus.rsp_valid = (state == ST_RESP);
        if (state == ST_IDLE && grant_valid && reset_n) begin
            bus.req_ready[grant_id] = 1'b1;
            advance                 = 1'b1;
        end
    end

    always_comb begin
        res_data = acc;
        res_flag = 1'b0;
        unique case (op_q)
            OP_SHR: begin
                res_data = acc;
            end
            OP_CMP: begin
                res_data = '0;
                res_flag = sgn_q ? ($signed(acc) > $signed(b_q)) : (acc > b_q);
            end
            OP_NEG: begin
                res_data = -acc;
                res_flag = sgn_q && (acc == MOST_NEG);
            end
            OP_ABS: begin
                if (sgn_q) begin
                    res_data = acc[WIDTH-1] ? (~acc + WIDTH'(1)) : acc;
                    res_flag = (acc == MOST_NEG);
                end
            end
        endcase
    end

    // NOTE: datapath and response registers are reset as well, because the
    // response outputs are observable and must read zero out of reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q         <= OP_SHR;
            sgn_q        <= 1'b0;
            id_q         <= 1'b0;
            acc          <= '0;
            b_q          <= '0;
            cnt          <= '0;
            bus.rsp_data <= '0;
            bus.rsp_flag <= 1'b0;
            bus.rsp_id   <= 1'b0;
        end else if (advance) begin
            op_q  <= sel_op;
            sgn_q <= sel_sgn;
            id_q  <= grant_id;
            acc   <= sel_a;
            b_q   <= sel_b;
            cnt   <= (sel_op == OP_SHR) ? sel_b[SHW-1:0] : '0;
        end else if (state == ST_EXEC) begin
            if (cnt != '0) begin
                acc <= sgn_q ? {acc[WIDTH-1], acc[WIDTH-1:1]} : {1'b0, acc[WIDTH-1:1]};
                cnt <= cnt - SHW'(1);
            end else begin
                bus.rsp_data <= res_data;
                bus.rsp_flag <= res_flag;
                bus.rsp_id   <= id_q;
            end
        end
    end

endmodule
